// File: rtl/bp_pe_array.sv
// Pipelined array of independent min-sum butterfly cells for LLR messages.
// Two register stages: S/G and clipped inputs, then the four output messages.
module bp_pe_array #(
    parameter int unsigned BIT   = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [1:0]             scale_mode,
    input  logic                   clr_sat,
    input  logic [LANES*BIT-1:0]   R_IN1,
    input  logic [LANES*BIT-1:0]   R_IN2,
    input  logic [LANES*BIT-1:0]   L_IN1,
    input  logic [LANES*BIT-1:0]   L_IN2,
    output logic [LANES*BIT-1:0]   R_OUT1,
    output logic [LANES*BIT-1:0]   R_OUT2,
    output logic [LANES*BIT-1:0]   L_OUT1,
    output logic [LANES*BIT-1:0]   L_OUT2,
    output logic                   out_valid,
    output logic [LANES-1:0]       sat_flag
);

    typedef logic [BIT-1:0] msg_t;

    localparam msg_t MinNeg = {1'b1, {(BIT-1){1'b0}}};
    localparam logic signed [BIT:0] MaxPos = {2'b00, {(BIT-1){1'b1}}};
    localparam logic signed [BIT:0] MaxNeg = -MaxPos;

    // The most negative code is folded onto -(2^(BIT-1)-1) so magnitudes fit in BIT-1 bits.
    function automatic msg_t clip(input msg_t x);
        return (x == MinNeg) ? x + msg_t'(1) : x;
    endfunction

    function automatic logic signed [BIT:0] add(input msg_t a, input msg_t b);
        return $signed({a[BIT-1], a}) + $signed({b[BIT-1], b});
    endfunction

    function automatic logic ovf(input logic signed [BIT:0] x);
        return (x > MaxPos) || (x < MaxNeg);
    endfunction

    function automatic msg_t sat(input logic signed [BIT:0] x);
        msg_t r;
        if (x > MaxPos)      r = MaxPos[BIT-1:0];
        else if (x < MaxNeg) r = MaxNeg[BIT-1:0];
        else                 r = x[BIT-1:0];
        return r;
    endfunction

    function automatic msg_t scale(input msg_t m, input logic [1:0] mode);
        msg_t r;
        case (mode)
            2'b01:   r = m - (m >> 2);
            2'b10:   r = m >> 1;
            2'b11:   r = m - (m >> 3);
            default: r = m;
        endcase
        return r;
    endfunction

    function automatic msg_t gfun(input msg_t a, input msg_t b, input logic [1:0] mode);
        msg_t ma, mb, m;
        ma = a[BIT-1] ? -a : a;
        mb = b[BIT-1] ? -b : b;
        m  = scale((ma < mb) ? ma : mb, mode);
        return (a[BIT-1] ^ b[BIT-1]) ? -m : m;
    endfunction

    msg_t [LANES-1:0] l1_c, l2_c, r1_c, r2_c, s_d, g_d;
    logic [LANES-1:0] ssat_d;

    msg_t [LANES-1:0] s_q, g_q, l1_q, r1_q, l2_q, r2_q;
    logic [LANES-1:0] ssat_q;
    logic [1:0]       mode_q;
    logic             v1_q;

    msg_t [LANES-1:0] lo1_d, lo2_d, ro1_d, ro2_d;
    logic [LANES-1:0] osat_d;
    logic [LANES-1:0] sat_d;

    always_comb begin
        l1_c   = '0;
        l2_c   = '0;
        r1_c   = '0;
        r2_c   = '0;
        s_d    = '0;
        g_d    = '0;
        ssat_d = '0;
        for (int k = 0; k < LANES; k++) begin
            l1_c[k]   = clip(L_IN1[k*BIT +: BIT]);
            l2_c[k]   = clip(L_IN2[k*BIT +: BIT]);
            r1_c[k]   = clip(R_IN1[k*BIT +: BIT]);
            r2_c[k]   = clip(R_IN2[k*BIT +: BIT]);
            s_d[k]    = sat(add(l2_c[k], r2_c[k]));
            ssat_d[k] = ovf(add(l2_c[k], r2_c[k]));
            g_d[k]    = gfun(r1_c[k], l1_c[k], scale_mode);
        end
    end

    // Stage 2 reuses the stage-1 mode sample so one transaction never mixes modes.
    always_comb begin
        lo1_d  = '0;
        lo2_d  = '0;
        ro1_d  = '0;
        ro2_d  = '0;
        osat_d = '0;
        for (int k = 0; k < LANES; k++) begin
            lo1_d[k]  = gfun(l1_q[k], s_q[k], mode_q);
            ro1_d[k]  = gfun(r1_q[k], s_q[k], mode_q);
            lo2_d[k]  = sat(add(g_q[k], l2_q[k]));
            ro2_d[k]  = sat(add(g_q[k], r2_q[k]));
            osat_d[k] = ovf(add(g_q[k], l2_q[k])) | ovf(add(g_q[k], r2_q[k]));
        end
        sat_d = (clr_sat ? '0 : sat_flag) | ({LANES{v1_q}} & (ssat_q | osat_d));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q       <= '0;
            g_q       <= '0;
            l1_q      <= '0;
            r1_q      <= '0;
            l2_q      <= '0;
            r2_q      <= '0;
            ssat_q    <= '0;
            mode_q    <= '0;
            v1_q      <= 1'b0;
            L_OUT1    <= '0;
            L_OUT2    <= '0;
            R_OUT1    <= '0;
            R_OUT2    <= '0;
            out_valid <= 1'b0;
            sat_flag  <= '0;
        end else if (en) begin
            s_q       <= s_d;
            g_q       <= g_d;
            l1_q      <= l1_c;
            r1_q      <= r1_c;
            l2_q      <= l2_c;
            r2_q      <= r2_c;
            ssat_q    <= ssat_d;
            mode_q    <= scale_mode;
            v1_q      <= in_valid;
            L_OUT1    <= lo1_d;
            L_OUT2    <= lo2_d;
            R_OUT1    <= ro1_d;
            R_OUT2    <= ro2_d;
            out_valid <= v1_q;
            sat_flag  <= sat_d;
        end
    end

endmodule

// File: tb/tb_bp_pe_array.sv
// Randomized bench for bp_pe_array against an integer-arithmetic transaction model.
module tb_bp_pe_array;

    localparam int BIT   = 8;
    localparam int LANES = 4;
    localparam int W     = BIT * LANES;

    logic         clk = 1'b0;
    logic         rst_n, en, in_valid, clr_sat;
    logic [1:0]   scale_mode;
    logic [W-1:0] R_IN1, R_IN2, L_IN1, L_IN2;
    logic [W-1:0] R_OUT1, R_OUT2, L_OUT1, L_OUT2;
    logic         out_valid;
    logic [LANES-1:0] sat_flag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bp_pe_array #(.BIT(BIT), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .scale_mode (scale_mode),
        .clr_sat    (clr_sat),
        .R_IN1      (R_IN1),
        .R_IN2      (R_IN2),
        .L_IN1      (L_IN1),
        .L_IN2      (L_IN2),
        .R_OUT1     (R_OUT1),
        .R_OUT2     (R_OUT2),
        .L_OUT1     (L_OUT1),
        .L_OUT2     (L_OUT2),
        .out_valid  (out_valid),
        .sat_flag   (sat_flag)
    );

    // One in-flight transaction as the model sees it: the finished results.
    typedef struct {
        bit           v;
        logic [W-1:0] lo1, lo2, ro1, ro2;
        logic [3:0]   sat;
    } slot_t;

    slot_t      st1, st2;
    logic [3:0] flag_m;
    bit         started = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clipv(input int x);
        return (x < -127) ? -127 : x;
    endfunction

    function automatic int satv(input int x);
        return (x > 127) ? 127 : ((x < -127) ? -127 : x);
    endfunction

    function automatic int gv(input int a, input int b, input int mode);
        int ma, mb, m;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        m  = (ma < mb) ? ma : mb;
        case (mode)
            1: m = m - m / 4;
            2: m = m / 2;
            3: m = m - m / 8;
            default: ;
        endcase
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    function automatic slot_t zero_slot();
        slot_t z;
        z.v = 0; z.lo1 = '0; z.lo2 = '0; z.ro1 = '0; z.ro2 = '0; z.sat = '0;
        return z;
    endfunction

    function automatic slot_t compute();
        slot_t r;
        int l1, l2, r1, r2, sr, s, g, a, b;
        r = zero_slot();
        for (int k = 0; k < LANES; k++) begin
            l1 = clipv(int'($signed(L_IN1[k*BIT +: BIT])));
            l2 = clipv(int'($signed(L_IN2[k*BIT +: BIT])));
            r1 = clipv(int'($signed(R_IN1[k*BIT +: BIT])));
            r2 = clipv(int'($signed(R_IN2[k*BIT +: BIT])));
            sr = l2 + r2;
            s  = satv(sr);
            g  = gv(r1, l1, int'(scale_mode));
            a  = g + l2;
            b  = g + r2;
            r.lo1[k*BIT +: BIT] = 8'(gv(l1, s, int'(scale_mode)));
            r.ro1[k*BIT +: BIT] = 8'(gv(r1, s, int'(scale_mode)));
            r.lo2[k*BIT +: BIT] = 8'(satv(a));
            r.ro2[k*BIT +: BIT] = 8'(satv(b));
            r.sat[k] = (sr != s) || (a != satv(a)) || (b != satv(b));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            st1 = zero_slot();
            st2 = zero_slot();
            flag_m = '0;
            started = 1;
        end else if (en) begin
            flag_m = (clr_sat ? 4'b0 : flag_m) | (st1.v ? st1.sat : 4'b0);
            st2 = st1;
            st1 = compute();
            st1.v = in_valid;
        end
        #1;
        if (started) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, st2.v});
            check("L_OUT1", L_OUT1, st2.lo1);
            check("L_OUT2", L_OUT2, st2.lo2);
            check("R_OUT1", R_OUT1, st2.ro1);
            check("R_OUT2", R_OUT2, st2.ro2);
            check("sat_flag", {28'b0, sat_flag}, {28'b0, flag_m});
        end
    endtask

    task automatic set_lane(input int k, input int l1, input int l2, input int r1, input int r2);
        L_IN1[k*BIT +: BIT] = 8'(l1);
        L_IN2[k*BIT +: BIT] = 8'(l2);
        R_IN1[k*BIT +: BIT] = 8'(r1);
        R_IN2[k*BIT +: BIT] = 8'(r2);
    endtask

    task automatic clear_in();
        L_IN1 = '0; L_IN2 = '0; R_IN1 = '0; R_IN2 = '0;
        in_valid = 0; clr_sat = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 0; en = 0; scale_mode = 2'b00;
        clear_in();
        idle(2);
        rst_n = 1; en = 1;
        idle(1);

        // Basic arithmetic
        set_lane(0, 10, 5, -3, 7); in_valid = 1; tick();
        clear_in(); idle(3);

        // Saturation, then sticky flag and clear
        set_lane(0, 127, 100, -128, 100); in_valid = 1; tick();
        clear_in(); idle(4);
        clr_sat = 1; tick();
        clr_sat = 0; idle(2);

        // Scaling modes
        for (int m = 0; m < 4; m++) begin
            scale_mode = 2'(m);
            set_lane(0, 100, 0, -40, 0); in_valid = 1; tick();
            clear_in(); idle(3);
        end
        scale_mode = 2'b00;

        // Stall pattern with a stream of valid vectors
        begin
            bit pat [6] = '{1, 0, 1, 1, 0, 1};
            for (int i = 0; i < 6; i++) begin
                en = pat[i];
                L_IN1 = $urandom; L_IN2 = $urandom; R_IN1 = $urandom; R_IN2 = $urandom;
                in_valid = 1;
                tick();
            end
            clear_in(); en = 1; idle(3);
        end

        // Reset mid-stream
        set_lane(0, 20, 30, -40, 50); in_valid = 1; tick();
        clear_in(); rst_n = 0; tick();
        rst_n = 1; idle(4);

        // Lane independence, only lane 2 saturates
        set_lane(0, 10, 5, -3, 7);
        set_lane(1, -20, 15, 30, -8);
        set_lane(2, 50, 100, -60, 100);
        set_lane(3, 1, -1, 2, -2);
        in_valid = 1; tick();
        clear_in(); idle(3);
        clr_sat = 1; tick();
        clr_sat = 0; idle(1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en         = ($urandom_range(0, 3) != 0);
            in_valid   = $urandom_range(0, 1);
            scale_mode = 2'($urandom_range(0, 3));
            clr_sat    = ($urandom_range(0, 9) == 0);
            rst_n      = ($urandom_range(0, 99) != 0);
            L_IN1 = $urandom; L_IN2 = $urandom; R_IN1 = $urandom; R_IN2 = $urandom;
            tick();
        end
        rst_n = 1; en = 1; clear_in(); idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
